add_seq_ctrl: RTL and testbench
===============================

# add_seq_ctrl

Multi-cycle add/subtract sequencer that computes a WIDTH-bit result by time-multiplexing one 4-bit ripple-carry adder slice over successive nibbles, least-significant first, with the carry held in a register between cycles. It sits between an operand producer and a result consumer, each connected through a valid/ready handshake. It trades latency for area on wide operands.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  producer presents an operation.
- start_ready  out  1  block can accept; high exactly when state is IDLE.
- a  in  W  operand A, sampled only at accept.
- b  in  W  operand B, sampled only at accept.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  1 = A-B (two's complement), 0 = A+B+cin; sampled at accept.
- res_valid  out  1  result available; high exactly when state is DONE.
- res_ready  in  1  consumer takes result.
- sum  out  W  result; registered.
- cout  out  1  final carry out; for sub, 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid (accept edge), capture a into a_q. Capture b_q = sub ? ~b : b. Set carry_q = sub ? 1 : cin. Set idx=0, clear sum. Go to RUN.
- RUN: each cycle, slice computes a_q[idx], b_q[idx] and carry_q. The nibble result is written to sum[idx] and carry_q takes the slice carry-out. On idx==NIBBLES-1: drive cout, set ovf from the slice MSB carries, and go to DONE. Otherwise idx increments.
- DONE: res_valid=1. sum, cout and ovf are held stable. On res_ready, go to IDLE.
- start_valid outside IDLE has no effect, and the pending request is not latched. a, b, cin and sub changes after accept have no effect.
- sum, cout and ovf keep their values in IDLE until the next accept clears sum.
- Reset, any state: state=IDLE, idx=0, carry_q=0, sum=0, cout=0, ovf=0, res_valid=0. start_ready reads 1 while rst is high and after it is released.
- Reset during RUN or DONE aborts the operation. No res_valid is produced for it.
- NIBBLES=1: RUN lasts one cycle, then DONE.

## Timing
- Latency: res_valid rises NIBBLES clock edges after the accept edge.
- DONE lasts at least 1 cycle. If res_ready is already high on entry, DONE lasts exactly 1 cycle.
- Earliest next accept is the edge after the result-handshake edge. Minimum period between accepts is NIBBLES+2 cycles.
- Combinational paths:
  - start_ready and res_valid decode state only.
  - There is no combinational path from any input to any output.
- Critical path is one 4-bit ripple chain plus the nibble mux. It is independent of NIBBLES apart from mux depth.

## Structure
- Package add_seq_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE_W = 4;
  - localparam helper for the idx width, $clog2 of NIBBLES with minimum 1.
- One sub-module, nibble_adder: a combinational 4-bit ripple-carry slice built from 1-bit full adders. Outputs are 4-bit sum, carry-out, and carry into bit 3 (used for ovf).
- Controller holds the FSM, idx counter, operand registers, carry register and result register.

## Test plan
NIBBLES=4 throughout.
- 0x1234 + 0x4321, cin=0, res_ready=1 -> sum=0x5555, cout=0, ovf=0. res_valid high exactly 4 edges after accept, for 1 cycle.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also 0xFFFF + 0x0000 with cin=1 -> same result.
- 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Also sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- sub 0x0005 - 0x0007 with cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
- Hold res_ready=0 for 5 cycles in DONE while driving start_valid=1 with new operands:
  - sum, cout and ovf stay stable; start_ready=0; the second request is not accepted.
  - After res_ready=1 for one edge, start_ready=1 and the second operation completes correctly.
- Assert rst in the second RUN cycle -> immediately state=IDLE, sum=0, res_valid=0, start_ready=1. No res_valid for the aborted operation, and the next add completes with correct timing.

Source files
------------

// File: rtl/add_seq_pkg.sv
// ============================================================================
// Module   : add_seq_pkg
// Brief    : Shared types and constants for the nibble-serial add/sub sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble operand still needs a 1-bit counter.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_adder.sv
// ============================================================================
// Module   : nibble_adder
// Brief    : Combinational 4-bit ripple-carry slice built from full adders
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_adder
    import add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[NIBBLE_W];
    // Carry into the top bit, needed for signed overflow on the final nibble.
    assign c3 = c[NIBBLE_W-1];

endmodule

`default_nettype wire

// File: rtl/add_seq_ctrl.sv
// ============================================================================
// Module   : add_seq_ctrl
// Brief    : Nibble-serial add/subtract sequencer with valid/ready handshakes
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [4*NIBBLES-1:0]      a,
    input  logic [4*NIBBLES-1:0]      b,
    input  logic                      cin,
    input  logic                      sub,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [4*NIBBLES-1:0]      sum,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;
    logic            ovf_q,   ovf_d;

    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_s;
    logic                slice_co, slice_c3;

    assign slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    // Subtraction is A + ~B + 1, so cin is overridden.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
                carry_d = slice_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_co;
                    ovf_d   = slice_co ^ slice_c3;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
// ============================================================================
// Module   : tb_add_seq_ctrl
// Brief    : Self-checking bench: arithmetic reference model plus directed cases
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_add_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    add_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: an operation is either pending (counting edges) or done.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_cnt  = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W-1:0] p_sum  = '0;
    logic         p_cout = 1'b0;
    logic         p_ovf  = 1'b0;

    function automatic logic [W+1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic c, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   full;
        logic         v;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : c)};
        v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_done) begin
            if (res_ready) m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt + 1 == NIB) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_sum  <= p_sum;
                m_cout <= p_cout;
                m_ovf  <= p_ovf;
            end
            m_cnt <= m_cnt + 1;
        end else if (start_valid) begin
            {p_ovf, p_cout, p_sum} <= ref_result(a, b, cin, sub);
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_sum  <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("start_ready", {31'd0, start_ready}, {31'd0, ~(m_busy | m_done)});
        chk("res_valid",   {31'd0, res_valid},   {31'd0, m_done});
        if (m_done) begin
            chk("sum",  {16'd0, sum},       {16'd0, m_sum});
            chk("cout", {31'd0, cout},      {31'd0, m_cout});
            chk("ovf",  {31'd0, ovf},       {31'd0, m_ovf});
        end else if (!m_busy) begin
            chk("idle_sum", {16'd0, sum},   {16'd0, m_sum});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        if (!res_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout: res_valid never rose, got 0 expected 1");
        end
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic xs, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string name);
        int n;
        a = xa; b = xb; cin = xc; sub = xs;
        start_valid = 1'b1;
        res_ready   = 1'b1;
        step();
        start_valid = 1'b0;
        wait_valid(n);
        chk({name, "_latency"}, n, NIB);
        chk({name, "_sum"},  {16'd0, sum},  {16'd0, es});
        chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({name, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        step();
        chk({name, "_done_1cyc"}, {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        step();
        step();
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_res_valid",   {31'd0, res_valid},   32'd0);
        chk("rst_sum",         {16'd0, sum},         32'd0);
        chk("rst_cout_ovf",    {30'd0, cout, ovf},   32'd0);
        rst = 1'b0;
        step();

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "add_cin");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");

        // Back-pressure: result held while a second request waits.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        start_valid = 1'b1;
        res_ready   = 1'b0;
        step();
        start_valid = 1'b0;
        wait_valid(n);
        a = 16'hAAAA; b = 16'h1111; start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_sum",   {16'd0, sum},   32'h3333);
            chk("hold_flags", {30'd0, cout, ovf}, 32'd0);
            chk("hold_busy",  {31'd0, start_ready}, 32'd0);
        end
        res_ready = 1'b1;
        step();
        chk("hs_start_ready", {31'd0, start_ready}, 32'd1);
        step();
        start_valid = 1'b0;
        wait_valid(n);
        chk("second_latency", n, NIB);
        chk("second_sum",     {16'd0, sum}, 32'hBBBB);
        chk("second_flags",   {30'd0, cout, ovf}, 32'd0);
        step();

        // Reset in the second RUN cycle aborts the operation.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("abort_start_ready", {31'd0, start_ready}, 32'd1);
        chk("abort_res_valid",   {31'd0, res_valid},   32'd0);
        chk("abort_sum",         {16'd0, sum},         32'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (res_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
